// File: rtl/uart_cmd_decoder.sv
// Command framer between uart_rx and motor_cntlr/uart_tx: parses 0x55-framed
// commands, holds the motor setpoint registers and streams encoder snapshots back.
module uart_cmd_decoder #(
  parameter int unsigned TIMEOUT_CLKS = 2000000,
  parameter logic [7:0]  DEF_SPEED    = 8'h80,
  parameter logic [15:0] DEF_TICS     = 16'd1440
) (
  input  logic        clk_100MHz,
  input  logic        rst_n,
  input  logic        i_Rx_DV,
  input  logic [7:0]  i_Rx_Byte,
  input  logic [23:0] i_EncCntL,
  input  logic [23:0] i_EncCntR,
  input  logic        i_Tx_Done,
  output logic        o_Tx_DV,
  output logic [7:0]  o_Tx_Byte,
  output logic [7:0]  o_speed1,
  output logic [7:0]  o_speed2,
  output logic [7:0]  o_accel,
  output logic [15:0] o_tics_per_rev,
  output logic        o_zero_encoders,
  output logic        o_cmd_ack,
  output logic [7:0]  o_err_cnt
);

  // state       | meaning
  // ST_IDLE     | hunting for the 0x55 sync byte
  // ST_CMD      | expecting the command byte
  // ST_DATA     | collecting 1..2 data bytes
  // ST_CHK      | expecting the XOR checksum byte
  // ST_EXEC     | one cycle: commit registers, take snapshot
  // ST_TX_SEND  | present one response byte to uart_tx
  // ST_TX_WAIT  | wait for uart_tx to finish that byte
  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_DATA, ST_CHK, ST_EXEC, ST_TX_SEND, ST_TX_WAIT
  } state_t;

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CLKS - 1);

  state_t            state_q, state_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [7:0]        xor_q, xor_d;
  logic [15:0]       data_q, data_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [23:0]       snap_q, snap_d;
  logic [1:0]        idx_q, idx_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic [7:0]        speed1_q, speed1_d;
  logic [7:0]        speed2_q, speed2_d;
  logic [7:0]        accel_q, accel_d;
  logic [15:0]       tics_q, tics_d;
  logic              zero_q, zero_d;
  logic              ack_q, ack_d;
  logic [7:0]        err_q, err_d;
  logic              err_evt;
  logic              cmd_known;
  logic [1:0]        cmd_len;
  logic [1:0]        idx_nxt;

  // Data-byte count per command; unknown codes (including a repeated 0x55) rejected.
  always_comb begin
    cmd_known = 1'b1;
    cmd_len   = 2'd0;
    case (i_Rx_Byte)
      8'h11:                cmd_len = 2'd2;
      8'h21, 8'h22, 8'h23:  cmd_len = 2'd1;
      8'h24, 8'h25, 8'h26:  cmd_len = 2'd0;
      default:              cmd_known = 1'b0;
    endcase
  end

  assign idx_nxt = idx_q + 2'd1;

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    cnt_d     = cnt_q;
    xor_d     = xor_q;
    data_d    = data_q;
    tmo_d     = tmo_q;
    snap_d    = snap_q;
    idx_d     = idx_q;
    tx_byte_d = tx_byte_q;
    speed1_d  = speed1_q;
    speed2_d  = speed2_q;
    accel_d   = accel_q;
    tics_d    = tics_q;
    zero_d    = 1'b0;
    ack_d     = 1'b0;
    err_evt   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tmo_d = TMO_LOAD;
        if (i_Rx_DV && i_Rx_Byte == 8'h55) state_d = ST_CMD;
      end

      ST_CMD, ST_DATA, ST_CHK: begin
        if (i_Rx_DV) begin
          tmo_d = TMO_LOAD;
          case (state_q)
            ST_CMD: begin
              if (cmd_known) begin
                cmd_d   = i_Rx_Byte;
                xor_d   = i_Rx_Byte;
                cnt_d   = cmd_len;
                state_d = (cmd_len != 2'd0) ? ST_DATA : ST_CHK;
              end else begin
                state_d = ST_IDLE;
                err_evt = 1'b1;
              end
            end
            ST_DATA: begin
              data_d = {data_q[7:0], i_Rx_Byte};
              xor_d  = xor_q ^ i_Rx_Byte;
              cnt_d  = cnt_q - 2'd1;
              if (cnt_q == 2'd1) state_d = ST_CHK;
            end
            default: begin
              if (i_Rx_Byte == xor_q) begin
                state_d = ST_EXEC;
              end else begin
                state_d = ST_IDLE;
                err_evt = 1'b1;
              end
            end
          endcase
        end else if (tmo_q == '0) begin
          // Terminal count reached with no byte this cycle: abandon the frame.
          state_d = ST_IDLE;
          err_evt = 1'b1;
        end else begin
          tmo_d = tmo_q - TMO_W'(1);
        end
      end

      ST_EXEC: begin
        err_evt = i_Rx_DV;
        ack_d   = 1'b1;
        state_d = ST_IDLE;
        case (cmd_q)
          8'h11: tics_d   = data_q;
          8'h21: speed1_d = data_q[7:0];
          8'h22: speed2_d = data_q[7:0];
          8'h23: accel_d  = data_q[7:0];
          8'h24: begin
            snap_d    = i_EncCntL;
            tx_byte_d = 8'hFD;
            idx_d     = 2'd0;
            state_d   = ST_TX_SEND;
          end
          8'h25: begin
            snap_d    = i_EncCntR;
            tx_byte_d = 8'hFE;
            idx_d     = 2'd0;
            state_d   = ST_TX_SEND;
          end
          8'h26: zero_d = 1'b1;
          default: ;
        endcase
      end

      ST_TX_SEND: begin
        err_evt = i_Rx_DV;
        state_d = ST_TX_WAIT;
      end

      ST_TX_WAIT: begin
        err_evt = i_Rx_DV;
        if (i_Tx_Done) begin
          if (idx_q == 2'd3) begin
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_nxt;
            state_d = ST_TX_SEND;
            case (idx_nxt)
              2'd1:    tx_byte_d = snap_q[23:16];
              2'd2:    tx_byte_d = snap_q[15:8];
              default: tx_byte_d = snap_q[7:0];
            endcase
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    err_d = err_q;
    if (err_evt && err_q != 8'hFF) err_d = err_q + 8'd1;
  end

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cmd_q     <= '0;
      cnt_q     <= '0;
      xor_q     <= '0;
      data_q    <= '0;
      tmo_q     <= TMO_LOAD;
      snap_q    <= '0;
      idx_q     <= '0;
      tx_byte_q <= '0;
      speed1_q  <= DEF_SPEED;
      speed2_q  <= DEF_SPEED;
      accel_q   <= '0;
      tics_q    <= DEF_TICS;
      zero_q    <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      cnt_q     <= cnt_d;
      xor_q     <= xor_d;
      data_q    <= data_d;
      tmo_q     <= tmo_d;
      snap_q    <= snap_d;
      idx_q     <= idx_d;
      tx_byte_q <= tx_byte_d;
      speed1_q  <= speed1_d;
      speed2_q  <= speed2_d;
      accel_q   <= accel_d;
      tics_q    <= tics_d;
      zero_q    <= zero_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
    end
  end

  assign o_Tx_DV         = (state_q == ST_TX_SEND);
  assign o_Tx_Byte       = tx_byte_q;
  assign o_speed1        = speed1_q;
  assign o_speed2        = speed2_q;
  assign o_accel         = accel_q;
  assign o_tics_per_rev  = tics_q;
  assign o_zero_encoders = zero_q;
  assign o_cmd_ack       = ack_q;
  assign o_err_cnt       = err_q;

endmodule
